weight_load_sequencer: RTL and testbench

- Loads pretrained weights into one layer of neurons.
- Accepts a host stream of 32-bit weight words over a valid/ready handshake.
- Tags each word with layer number, neuron number and weight index, then broadcasts it on the neuron weight-config bus: weight_valid, weight_value, config_layer_no, config_neuron_no.
- Sits between the host/DMA interface and the neuron array. One start programs one full layer.

---
 rtl/weight_load_sequencer_if.sv | 14 +
 rtl/weight_load_sequencer.sv | 149 ++++++++++++++
 tb/tb_weight_load_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_load_sequencer_if.sv
// Host weight stream: valid/ready handshake carrying one weight word per beat.
//   s_valid  host -> sequencer  word present on s_data
//   s_data   host -> sequencer  weight word
//   s_ready  sequencer -> host  sequencer accepts a word this cycle
interface weight_load_sequencer_if #(
    parameter int data_width = 32
);
    logic                  s_valid;
    logic [data_width-1:0] s_data;
    logic                  s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/weight_load_sequencer.sv
// Weight load sequencer: programs one layer of neurons per start. Each host
// word is tagged with layer, neuron and weight index and broadcast on the
// neuron weight-config bus one cycle after it is accepted.
//   clk, reset            clock (rising edge), async active-low reset
//   start, abort          begin a layer load (IDLE only) / cancel a load
//   cfg_layer_no          layer tag, latched at start
//   cfg_num_neurons       neurons in the layer, latched at start
//   cfg_num_weights       weights per neuron, latched at start
//   s_if                  host stream (slave side)
//   weight_valid/value    broadcast word
//   config_layer_no       layer tag of the broadcast word
//   config_neuron_no      target neuron (zero-extended counter)
//   weight_addr           weight index within the target neuron
//   busy, done, err       load in progress / completion pulse / rejected start
module weight_load_sequencer #(
    parameter int cnt_bits   = 16,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           cfg_layer_no,
    input  logic [cnt_bits-1:0]   cfg_num_neurons,
    input  logic [cnt_bits-1:0]   cfg_num_weights,
    weight_load_sequencer_if.slave s_if,
    output logic                  weight_valid,
    output logic [data_width-1:0] weight_value,
    output logic [31:0]           config_layer_no,
    output logic [31:0]           config_neuron_no,
    output logic [cnt_bits-1:0]   weight_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t                r_state;
    logic [31:0]           r_layer;
    logic [cnt_bits-1:0]   r_num_neurons;
    logic [cnt_bits-1:0]   r_num_weights;
    logic [cnt_bits-1:0]   r_neuron_cnt;
    logic [cnt_bits-1:0]   r_weight_cnt;
    logic                  r_weight_valid;
    logic [data_width-1:0] r_weight_value;
    logic [31:0]           r_config_layer_no;
    logic [31:0]           r_config_neuron_no;
    logic [cnt_bits-1:0]   r_weight_addr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic w_accept;
    logic w_last_w;
    logic w_last_n;

    // Ready depends only on state so the host never sees a combinational loop.
    assign s_if.s_ready = (r_state == S_LOAD);
    assign w_accept     = s_if.s_valid && (r_state == S_LOAD);
    // Counts are nonzero whenever in LOAD, so the "-1" never underflows and
    // the counters never need to reach the count itself (no overflow at max).
    assign w_last_w     = (r_weight_cnt == r_num_weights - cnt_bits'(1));
    assign w_last_n     = (r_neuron_cnt == r_num_neurons - cnt_bits'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= S_IDLE;
            r_layer            <= '0;
            r_num_neurons      <= '0;
            r_num_weights      <= '0;
            r_neuron_cnt       <= '0;
            r_weight_cnt       <= '0;
            r_weight_valid     <= 1'b0;
            r_weight_value     <= '0;
            r_config_layer_no  <= '0;
            r_config_neuron_no <= '0;
            r_weight_addr      <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_err              <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_weight_valid <= w_accept;

            // Broadcast stage: tags reflect the counters before this beat's update.
            if (w_accept) begin
                r_weight_value     <= s_if.s_data;
                r_config_layer_no  <= r_layer;
                r_config_neuron_no <= 32'(r_neuron_cnt);
                r_weight_addr      <= r_weight_cnt;
            end

            case (r_state)
                S_IDLE: begin
                    // abort outranks start while idle
                    if (start && !abort) begin
                        if (cfg_num_neurons == '0 || cfg_num_weights == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_layer       <= cfg_layer_no;
                            r_num_neurons <= cfg_num_neurons;
                            r_num_weights <= cfg_num_weights;
                            r_neuron_cnt  <= '0;
                            r_weight_cnt  <= '0;
                            r_busy        <= 1'b1;
                            r_state       <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_neuron_cnt <= '0;
                        r_weight_cnt <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (w_accept) begin
                        if (w_last_w) begin
                            r_weight_cnt <= '0;
                            if (w_last_n) begin
                                // Final beat: done/busy-low line up with its broadcast.
                                r_neuron_cnt <= '0;
                                r_busy       <= 1'b0;
                                r_done       <= 1'b1;
                                r_state      <= S_IDLE;
                            end else begin
                                r_neuron_cnt <= r_neuron_cnt + cnt_bits'(1);
                            end
                        end else begin
                            r_weight_cnt <= r_weight_cnt + cnt_bits'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign weight_valid     = r_weight_valid;
    assign weight_value     = r_weight_value;
    assign config_layer_no  = r_config_layer_no;
    assign config_neuron_no = r_config_neuron_no;
    assign weight_addr      = r_weight_addr;
    assign busy             = r_busy;
    assign done             = r_done;
    assign err              = r_err;

endmodule

// File: tb/tb_weight_load_sequencer.sv
module tb_weight_load_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] cfg_layer_no;
    logic [15:0] cfg_num_neurons;
    logic [15:0] cfg_num_weights;
    logic        weight_valid;
    logic [31:0] weight_value;
    logic [31:0] config_layer_no;
    logic [31:0] config_neuron_no;
    logic [15:0] weight_addr;
    logic        busy;
    logic        done;
    logic        err;

    weight_load_sequencer_if #(.data_width(32)) sif ();

    weight_load_sequencer #(.cnt_bits(16), .data_width(32)) dut (
        .clk              (clk),
        .reset            (rst_n),
        .start            (start),
        .abort            (abort),
        .cfg_layer_no     (cfg_layer_no),
        .cfg_num_neurons  (cfg_num_neurons),
        .cfg_num_weights  (cfg_num_weights),
        .s_if             (sif),
        .weight_valid     (weight_valid),
        .weight_value     (weight_value),
        .config_layer_no  (config_layer_no),
        .config_neuron_no (config_neuron_no),
        .weight_addr      (weight_addr),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        logic [31:0] layer;
        logic [31:0] neuron;
        logic [15:0] addr;
        logic        dn;
        logic        bsy;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops an expected entry on every broadcast word.
    always @(negedge clk) begin
        if (weight_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_weight_valid", 64'(weight_valid), 64'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("weight_value",     64'(weight_value),     64'(e.val));
                chk("config_layer_no",  64'(config_layer_no),  64'(e.layer));
                chk("config_neuron_no", 64'(config_neuron_no), 64'(e.neuron));
                chk("weight_addr",      64'(weight_addr),      64'(e.addr));
                chk("done_with_wv",     64'(done),             64'(e.dn));
                chk("busy_with_wv",     64'(busy),             64'(e.bsy));
                chk("wv_latency_cycle", 64'(cyc),              64'(e.cyc));
            end
        end else if (done) begin
            chk("done_without_wv", 64'(done), 64'(0));
        end
    end

    // Drives one layer load. stop_after>0 stops after that many beats (caller
    // then aborts or resets); hold_start keeps start high with different cfg.
    task automatic run_load(input logic [31:0] layer, input int n, input int w,
                            input logic [31:0] base, input bit throttle,
                            input bit hold_start, input int stop_after);
        int total;
        int beats;
        exp_t e;
        total = n * w;
        beats = (stop_after > 0) ? stop_after : total;
        start = 1'b1;
        cfg_layer_no = layer;
        cfg_num_neurons = 16'(n);
        cfg_num_weights = 16'(w);
        @(posedge clk); #1;
        start = hold_start;
        if (hold_start) begin
            cfg_layer_no = layer + 32'd7;
            cfg_num_neurons = 16'd1;
            cfg_num_weights = 16'd1;
        end
        chk("busy_after_start", 64'(busy), 64'(1));
        for (int k = 0; k < beats; k++) begin
            if (throttle && k > 0) begin
                sif.s_valid = 1'b0;
                @(posedge clk); #1;
            end
            chk("s_ready_in_load", 64'(sif.s_ready), 64'(1));
            sif.s_valid = 1'b1;
            sif.s_data  = base + 32'(k);
            if (hold_start && k == total - 1) start = 1'b0;
            e.val    = base + 32'(k);
            e.layer  = layer;
            e.neuron = 32'(k / w);
            e.addr   = 16'(k % w);
            e.dn     = (stop_after == 0) && (k == total - 1);
            e.bsy    = !e.dn;
            e.cyc    = cyc + 1;
            q.push_back(e);
            @(posedge clk); #1;
        end
        sif.s_valid = 1'b0;
        start = 1'b0;
        if (stop_after == 0) chk("s_ready_after_final", 64'(sif.s_ready), 64'(0));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_layer_no = '0;
        cfg_num_neurons = '0;
        cfg_num_weights = '0;
        sif.s_valid = 1'b0;
        sif.s_data = '0;
        idle_cycles(2);
        chk("rst_busy",   64'(busy),         64'(0));
        chk("rst_wv",     64'(weight_valid), 64'(0));
        chk("rst_sready", 64'(sif.s_ready),  64'(0));
        chk("rst_done",   64'(done),         64'(0));
        chk("rst_err",    64'(err),          64'(0));
        rst_n = 1'b1;
        idle_cycles(1);

        // Normal load: 3 neurons x 4 weights, continuous stream
        run_load(32'd2, 3, 4, 32'h100, 1'b0, 1'b0, 0);
        idle_cycles(2);

        // Throttled stream, same configuration
        run_load(32'd2, 3, 4, 32'h100, 1'b1, 1'b0, 0);
        idle_cycles(2);

        // Zero-count reject
        start = 1'b1; cfg_layer_no = 32'd4; cfg_num_neurons = 16'd0; cfg_num_weights = 16'd5;
        sif.s_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("reject_err",    64'(err),         64'(1));
        chk("reject_busy",   64'(busy),        64'(0));
        chk("reject_sready", 64'(sif.s_ready), 64'(0));
        @(posedge clk); #1;
        sif.s_valid = 1'b0;
        chk("reject_err_once", 64'(err),  64'(0));
        chk("reject_busy2",    64'(busy), 64'(0));
        idle_cycles(1);

        // Abort after 3 beats of a 2x2 load
        run_load(32'd3, 2, 2, 32'h200, 1'b0, 1'b0, 3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy",   64'(busy),        64'(0));
        chk("abort_sready", 64'(sif.s_ready), 64'(0));
        idle_cycles(1);
        run_load(32'd5, 1, 1, 32'h300, 1'b0, 1'b0, 0);
        idle_cycles(2);

        // Abort while idle outranks start
        abort = 1'b1; start = 1'b1;
        cfg_num_neurons = 16'd1; cfg_num_weights = 16'd1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'(0));
        chk("idle_abort_err",  64'(err),  64'(0));
        idle_cycles(1);

        // Mid-load asynchronous reset after 5 beats
        run_load(32'd6, 2, 4, 32'h400, 1'b0, 1'b0, 5);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("areset_wv",     64'(weight_valid),     64'(0));
        chk("areset_busy",   64'(busy),             64'(0));
        chk("areset_sready", 64'(sif.s_ready),      64'(0));
        chk("areset_value",  64'(weight_value),     64'(0));
        chk("areset_layer",  64'(config_layer_no),  64'(0));
        chk("areset_neuron", 64'(config_neuron_no), 64'(0));
        chk("areset_addr",   64'(weight_addr),      64'(0));
        chk("areset_done",   64'(done),             64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(1);
        run_load(32'd8, 1, 2, 32'h500, 1'b0, 1'b0, 0);
        idle_cycles(2);

        // Start held during LOAD with different cfg: no re-latch, no restart
        run_load(32'd7, 2, 2, 32'h600, 1'b0, 1'b1, 0);
        idle_cycles(2);
        chk("collision_idle_busy", 64'(busy), 64'(0));

        // Single-weight layer
        run_load(32'd9, 1, 1, 32'hDEADBEEF, 1'b0, 1'b0, 0);
        idle_cycles(3);

        chk("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
